// File: rtl/pe_skid_stage.sv
// Two-entry skid stage: main register drives out_data, skid absorbs one beat.
// Handshake outputs come straight from registers so no combinational path crosses the stage.
module pe_skid_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  beat_count,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              in_ready_q;
    logic              in_ready_d;
    logic              out_valid_q;
    logic              out_valid_d;

    logic in_hs;
    logic out_hs;

    assign in_hs  = in_valid && in_ready_q;
    assign out_hs = out_valid_q && out_ready;

    // Next state, data movement and registered handshake flags.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        if (out_hs) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        unique case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    state_d = HOLD;
                    main_d  = in_data;
                end
            end
            HOLD: begin
                unique case (1'b1)
                    (in_hs && !out_hs): begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end
                    (!in_hs && out_hs): begin
                        state_d = EMPTY;
                    end
                    (in_hs && out_hs): begin
                        main_d = in_data;
                    end
                    default: begin
                        state_d = HOLD;
                    end
                endcase
            end
            FULL: begin
                if (out_hs) begin
                    state_d = HOLD;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // State and storage registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = main_q;
    assign beat_count = cnt_q;
    assign occupancy  = state_q;

endmodule

// File: tb/tb_pe_skid_stage.sv
// Directed + random bench for pe_skid_stage with a queue scoreboard.
// A second instance with CNT_W=4 shares the stimulus to exercise counter wrap.
module tb_pe_skid_stage;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [15:0]   beat_count;
    logic [1:0]    occupancy;

    logic          in_ready4;
    logic          out_valid4;
    logic [DW-1:0] out_data4;
    logic [3:0]    beat_count4;
    logic [1:0]    occupancy4;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;

    logic [DW-1:0] sb[$];
    logic          stall_prev = 1'b0;
    logic [DW-1:0] data_prev  = '0;

    always #5 clk = ~clk;

    pe_skid_stage #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .beat_count (beat_count),
        .occupancy  (occupancy)
    );

    pe_skid_stage #(.DATA_W(DW), .CNT_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready4),
        .out_valid  (out_valid4),
        .out_data   (out_data4),
        .out_ready  (out_ready),
        .beat_count (beat_count4),
        .occupancy  (occupancy4)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: inputs are stable here; handshakes seen now happen at the next edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            chk("occupancy_vs_model", 64'(occupancy), 64'(sb.size()));
            if (occupancy == 2'd2) begin
                chk("in_ready_in_full", 64'(in_ready), 64'd0);
            end
            if (stall_prev) begin
                chk("stall_stable", 64'(out_data), 64'(data_prev));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(out_data), 64'hdead);
                end else begin
                    chk("out_data_order", 64'(out_data), 64'(sb.pop_front()));
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
        end
    end

    initial begin
        int base;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) step();

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_beat_count", 64'(beat_count), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        rst = 1'b0;

        // Single beat with one-cycle latency.
        in_valid  = 1'b1;
        in_data   = 32'd42;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_out_valid", 64'(out_valid), 64'd1);
        chk("single_out_data", 64'(out_data), 64'd42);
        step();
        chk("single_beat_count", 64'(beat_count), 64'd1);
        chk("single_drained", 64'(occupancy), 64'd0);

        // Backpressure: 1 and 2 stored, 3 held upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd1;
        step();
        in_data = 32'd2;
        step();
        in_data = 32'd3;
        step();
        chk("bp_occupancy", 64'(occupancy), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_data", 64'(out_data), 64'd1);
        step();
        chk("bp_hold_data", 64'(out_data), 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_second", 64'(out_data), 64'd2);
        step();
        in_valid = 1'b0;
        chk("bp_third", 64'(out_data), 64'd3);
        step();
        chk("bp_beat_count", 64'(beat_count), 64'd4);
        chk("bp_empty", 64'(occupancy), 64'd0);

        // Streaming 100 beats, no bubbles after the first.
        base = n_out;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 32'(100 + i);
            step();
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_data", 64'(out_data), 64'(100 + i));
        end
        in_valid = 1'b0;
        step();
        chk("stream_delivered", 64'(n_out - base), 64'd100);
        chk("stream_beat_count", 64'(beat_count), 64'd104);
        chk("stream_beat_count4", 64'(beat_count4), 64'd8);

        // Reset while FULL discards 7 and 8.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd7;
        step();
        in_data = 32'd8;
        step();
        in_valid = 1'b0;
        chk("mid_full", 64'(occupancy), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_occupancy", 64'(occupancy), 64'd0);
        chk("mid_beat_count", 64'(beat_count), 64'd0);
        chk("mid_in_ready", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_data   = 32'd9;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("mid_nine", 64'(out_data), 64'd9);
        step();
        chk("mid_alone", 64'(occupancy), 64'd0);
        chk("mid_count", 64'(beat_count), 64'd1);

        // Counter wrap on the 4-bit instance.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("wrap_start", 64'(beat_count4), 64'd0);
        in_valid = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            in_data = 32'(200 + k);
            if (k == 18) in_valid = 1'b0;
            step();
            if (k >= 16) begin
                chk("wrap_count4", 64'(beat_count4), 64'((k - 1) % 16));
                chk("wrap_count16", 64'(beat_count), 64'(k - 1));
            end
        end
        step();

        // Random traffic.
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("final_drain", 64'(sb.size()), 64'd0);
        chk("final_empty", 64'(occupancy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pe_skid_stage.md
PE_SKID_STAGE -- requirements
Module: pe_skid_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the beat counter width in bits.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port in_valid  input  1  upstream offers in_data this cycle.
REQ-006 Port in_data  input  DATA_W  upstream payload.
REQ-007 Port in_ready  output  1  block accepts in_data this cycle.
REQ-008 Port out_valid  output  1  out_data holds a valid beat for the downstream pipe register.
REQ-009 Port out_data  output  DATA_W  downstream payload.
REQ-010 Port out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 Port beat_count  output  CNT_W  count of beats delivered downstream.
REQ-012 Port occupancy  output  2  number of beats held (0, 1 or 2).

Function
REQ-013 An input handshake SHALL occur on a rising edge where in_valid && in_ready; an output handshake SHALL occur on a rising edge where out_valid && out_ready.
REQ-014 Storage SHALL be a main register (drives out_data) plus one skid register; no other buffering.
REQ-015 The state machine SHALL have states EMPTY (occupancy 0), HOLD (1), FULL (2).
REQ-016 EMPTY: input handshake -> HOLD, payload into main; otherwise stay.
REQ-017 HOLD: input-only -> FULL, payload into skid; output-only -> EMPTY; both -> stay HOLD, new payload into main.
REQ-018 FULL: output handshake -> HOLD, skid moves to main; otherwise stay; no input handshake possible.
REQ-019 in_ready SHALL be 1 in EMPTY and HOLD and 0 in FULL, driven from a register and never combinationally from out_ready.
REQ-020 out_valid SHALL be 1 exactly in HOLD and FULL, driven from a register.
REQ-021 Latency SHALL be one cycle: a beat accepted at edge N is on out_data with out_valid=1 immediately after edge N when the stage was EMPTY.
REQ-022 Sustained throughput SHALL be one beat per cycle when in_valid and out_ready are held high.
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-024 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-025 beat_count SHALL increment by 1 on each output handshake and wrap from 2^CNT_W-1 to 0.
REQ-026 out_data SHALL keep its last value when the stage is EMPTY; content is don't-care while out_valid=0.
REQ-027 in_data while in_valid=0, and out_ready while out_valid=0, SHALL have no effect.

Reset
REQ-028 While rst=1 at a rising edge, the next state SHALL be EMPTY: out_valid=0, in_ready=1, out_data=0, beat_count=0, occupancy=0, skid register=0.
REQ-029 Reset SHALL take priority over any simultaneous handshake; beats held when rst is asserted SHALL be discarded.
REQ-030 Handshakes SHALL be honoured from the first rising edge with rst=0.

Verification
REQ-031 Reset then single beat: rst high 3 cycles, in_data=42 with in_valid=1 for one edge, out_ready=1 -> out_valid=1, out_data=42 one cycle later; beat_count=1 after the next edge.
REQ-032 Backpressure: out_ready=0, in_data 1, 2, 3 offered on consecutive edges -> 1 and 2 accepted, occupancy=2, in_ready=0, 3 held upstream; after out_ready=1, outputs 1, 2, 3 in order.
REQ-033 Streaming: in_valid=out_ready=1 for 100 cycles with an incrementing payload -> 100 beats out, in order, no bubbles after the first, beat_count=100.
REQ-034 Random: random in_valid/out_ready for 10k cycles -> scoreboard matches exactly, out_data stable under stall, in_ready never high in FULL.
REQ-035 Reset mid-operation: FULL with 7 and 8 held, rst pulsed one cycle -> out_valid=0, occupancy=0, beat_count=0; next beat 9 emerges alone.
REQ-036 Counter wrap: CNT_W=4, 17 beats delivered -> beat_count reads 15 after the 15th beat, 0 after the 16th, 1 after the 17th.
